// File: rtl/aref_if.sv
// Refresh scheduler <-> command arbiter bundle: init status, grant/request
// handshake and the refresh command bus.
interface aref_if;
  logic        init_end;
  logic        aref_en;
  logic        aref_req;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank;
  logic [12:0] aref_addr;
  logic        aref_miss;

  modport master (
    input  init_end,
    input  aref_en,
    output aref_req,
    output aref_end,
    output aref_cmd,
    output aref_bank,
    output aref_addr,
    output aref_miss
  );

  modport slave (
    output init_end,
    output aref_en,
    input  aref_req,
    input  aref_end,
    input  aref_cmd,
    input  aref_bank,
    input  aref_addr,
    input  aref_miss
  );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh scheduler: interval timer, owed-refresh backlog and the
// PRECHARGE-all + AUTO_REFRESH command sequencer driven once the arbiter grants.
module sdram_aref #(
  parameter int REF_INTERVAL = 750,
  parameter int TRP          = 2,
  parameter int TRFC         = 7,
  parameter int AREF_NUM     = 2
) (
  input  logic   aref_clk,
  input  logic   aref_rst_n,
  aref_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PCH   = 3'd1,
    ST_WTRP  = 3'd2,
    ST_AREF  = 3'd3,
    ST_WTRFC = 3'd4,
    ST_END   = 3'd5
  } state_t;

  localparam logic [3:0]  CMD_NOP       = 4'b0111;
  localparam logic [3:0]  CMD_PCH       = 4'b0010;
  localparam logic [3:0]  CMD_AREF      = 4'b0001;
  localparam logic [12:0] ADDR_IDLE     = 13'h1fff;
  localparam logic [12:0] ADDR_PCH_ALL  = 13'h0400;
  localparam logic [15:0] INTERVAL_LAST = 16'(REF_INTERVAL - 1);
  localparam logic [3:0]  TRP_LAST      = 4'(TRP - 1);
  localparam logic [3:0]  TRFC_LAST     = 4'(TRFC - 1);
  localparam logic [1:0]  AREF_TOTAL    = 2'(AREF_NUM);

  state_t      state_r, state_nxt_s;
  logic [15:0] intv_cnt_r;
  logic        tick_s;
  logic        end_s;
  logic [1:0]  pend_r, pend_nxt_s;
  logic        miss_r, miss_nxt_s;
  logic [3:0]  wait_r, wait_nxt_s;
  logic [1:0]  ref_cnt_r, ref_cnt_nxt_s;
  logic [3:0]  cmd_r, cmd_nxt_s;
  logic [12:0] addr_r, addr_nxt_s;
  logic        req_r, end_r;

  assign tick_s = bus.init_end && (intv_cnt_r == INTERVAL_LAST);
  assign end_s  = (state_r == ST_END);

  // Refresh interval timer, parked at zero until initialisation completes
  always_ff @(posedge aref_clk or negedge aref_rst_n) begin
    if (!aref_rst_n) begin
      intv_cnt_r <= 16'd0;
    end else if (!bus.init_end || tick_s) begin
      intv_cnt_r <= 16'd0;
    end else begin
      intv_cnt_r <= intv_cnt_r + 16'd1;
    end
  end

  // Backlog of owed refreshes; a tick coinciding with completion cancels out
  always_comb begin
    pend_nxt_s = pend_r;
    miss_nxt_s = miss_r;
    if (!bus.init_end) begin
      pend_nxt_s = 2'd0;
    end else if (tick_s && !end_s) begin
      if (pend_r == 2'd3) begin
        miss_nxt_s = 1'b1;
      end else begin
        pend_nxt_s = pend_r + 2'd1;
      end
    end else if (end_s && !tick_s && (pend_r != 2'd0)) begin
      pend_nxt_s = pend_r - 2'd1;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Sequencer next state; once past IDLE the sequence ignores grant and init
  always_comb begin
    state_nxt_s   = state_r;
    wait_nxt_s    = 4'd0;
    ref_cnt_nxt_s = ref_cnt_r;
    case (state_r)
      ST_IDLE: begin
        ref_cnt_nxt_s = 2'd0;
        if (bus.aref_en && (pend_r != 2'd0)) begin
          state_nxt_s = ST_PCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PCH: state_nxt_s = ST_WTRP;
      ST_WTRP: begin
        if (wait_r == TRP_LAST) begin
          state_nxt_s = ST_AREF;
        end else begin
          wait_nxt_s = wait_r + 4'd1;
        end
      end
      ST_AREF: begin
        ref_cnt_nxt_s = ref_cnt_r + 2'd1;
        state_nxt_s   = ST_WTRFC;
      end
      ST_WTRFC: begin
        if (wait_r != TRFC_LAST) begin
          wait_nxt_s = wait_r + 4'd1;
        end else if (ref_cnt_r < AREF_TOTAL) begin
          state_nxt_s = ST_AREF;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      ST_END:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Command decode of the upcoming state so the bus outputs come straight from flops
  always_comb begin
    cmd_nxt_s  = CMD_NOP;
    addr_nxt_s = ADDR_IDLE;
    case (state_nxt_s)
      ST_PCH: begin
        cmd_nxt_s  = CMD_PCH;
        addr_nxt_s = ADDR_PCH_ALL;
      end
      ST_AREF: begin
        cmd_nxt_s  = CMD_AREF;
        addr_nxt_s = ADDR_IDLE;
      end
      default: begin
        cmd_nxt_s  = CMD_NOP;
        addr_nxt_s = ADDR_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge aref_clk or negedge aref_rst_n) begin
    if (!aref_rst_n) begin
      state_r   <= ST_IDLE;
      pend_r    <= 2'd0;
      miss_r    <= 1'b0;
      wait_r    <= 4'd0;
      ref_cnt_r <= 2'd0;
      cmd_r     <= CMD_NOP;
      addr_r    <= ADDR_IDLE;
      req_r     <= 1'b0;
      end_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pend_r    <= pend_nxt_s;
      miss_r    <= miss_nxt_s;
      wait_r    <= wait_nxt_s;
      ref_cnt_r <= ref_cnt_nxt_s;
      cmd_r     <= cmd_nxt_s;
      addr_r    <= addr_nxt_s;
      req_r     <= (state_nxt_s == ST_IDLE) && (pend_nxt_s != 2'd0);
      end_r     <= (state_nxt_s == ST_END);
    end
  end

  assign bus.aref_req  = req_r;
  assign bus.aref_end  = end_r;
  assign bus.aref_cmd  = cmd_r;
  assign bus.aref_bank = 2'b11;
  assign bus.aref_addr = addr_r;
  assign bus.aref_miss = miss_r;

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: directed phase table, hand-written reset/init corner
// cases and randomised grant/init traffic against a sequence-position model.
module tb_sdram_aref;
  localparam int N    = 100;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int ANUM = 2;
  localparam int LEN  = 2 + TRP + ANUM * (1 + TRFC);

  logic aref_clk = 1'b0;
  logic aref_rst_n;
  aref_if bus();

  sdram_aref #(.REF_INTERVAL(N), .TRP(TRP), .TRFC(TRFC), .AREF_NUM(ANUM)) dut (
    .aref_clk  (aref_clk),
    .aref_rst_n(aref_rst_n),
    .bus       (bus)
  );

  always #5 aref_clk = ~aref_clk;

  int checks = 0;
  int errors = 0;

  // Model: position within the refresh sequence (0 = idle, 1..LEN), owed count
  int m_edges, m_pend, m_pos;
  bit m_miss;
  logic req_d1, req_d2;

  typedef struct packed {
    logic        init;
    logic [1:0]  en_mode;   // 0 low, 1 high, 2 loop back aref_req one cycle late
    logic [15:0] n;
    logic        exp_req;
    logic        exp_end;
    logic [3:0]  exp_cmd;
    logic [12:0] exp_addr;
    logic        exp_miss;
  } vec_t;

  vec_t tbl [0:21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cmd(input int pos);
    if (pos == 1) return 'h2;
    if (pos >= 2 + TRP && pos < LEN && ((pos - (2 + TRP)) % (1 + TRFC)) == 0) return 'h1;
    return 'h7;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_pend = 0; m_pos = 0; m_miss = 1'b0;
  endtask

  task automatic model_edge(input logic init, input logic en);
    bit endc, tick;
    int old_p;
    endc  = (m_pos == LEN);
    old_p = m_pend;
    if (init) m_edges++; else m_edges = 0;
    tick = init && ((m_edges % N) == 0);
    if (!init) m_pend = 0;
    else if (tick && !endc) begin
      if (m_pend == 3) m_miss = 1'b1; else m_pend++;
    end else if (endc && !tick && m_pend > 0) m_pend--;
    if (m_pos == 0) begin
      if (en && old_p != 0) m_pos = 1;
    end else if (m_pos == LEN) m_pos = 0;
    else m_pos++;
  endtask

  task automatic check_model();
    chk("req",  int'(bus.aref_req),  int'(m_pos == 0 && m_pend != 0));
    chk("end",  int'(bus.aref_end),  int'(m_pos == LEN));
    chk("cmd",  int'(bus.aref_cmd),  exp_cmd(m_pos));
    chk("bank", int'(bus.aref_bank), 'h3);
    chk("addr", int'(bus.aref_addr), (m_pos == 1) ? 'h400 : 'h1fff);
    chk("miss", int'(bus.aref_miss), int'(m_miss));
  endtask

  task automatic step(input logic init, input logic en);
    bus.init_end = init;
    bus.aref_en  = en;
    @(posedge aref_clk);
    model_edge(init, en);
    #1;
    check_model();
    req_d2 = req_d1;
    req_d1 = bus.aref_req;
  endtask

  initial begin
    logic en_v;
    logic init_v;
    int   mode;

    //            init mode   n     req   end   cmd      addr      miss
    tbl[0]  = '{1'b0, 2'd1, 16'd2000, 1'b0, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 16'd99,   1'b0, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 16'd1,    1'b1, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 16'd2,    1'b0, 1'b0, 4'h2, 13'h0400, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 16'd3,    1'b0, 1'b0, 4'h1, 13'h1fff, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 16'd8,    1'b0, 1'b0, 4'h1, 13'h1fff, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 16'd8,    1'b0, 1'b1, 4'h7, 13'h1fff, 1'b0};
    tbl[7]  = '{1'b1, 2'd2, 16'd9,    1'b0, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 16'd170,  1'b1, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 16'd1,    1'b0, 1'b0, 4'h2, 13'h0400, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 16'd20,   1'b1, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[11] = '{1'b1, 2'd1, 16'd1,    1'b0, 1'b0, 4'h2, 13'h0400, 1'b0};
    tbl[12] = '{1'b1, 2'd1, 16'd19,   1'b0, 1'b1, 4'h7, 13'h1fff, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 16'd1,    1'b0, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 16'd357,  1'b1, 1'b0, 4'h7, 13'h1fff, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 16'd1,    1'b1, 1'b0, 4'h7, 13'h1fff, 1'b1};
    tbl[16] = '{1'b1, 2'd1, 16'd62,   1'b0, 1'b1, 4'h7, 13'h1fff, 1'b1};
    tbl[17] = '{1'b1, 2'd0, 16'd1,    1'b0, 1'b0, 4'h7, 13'h1fff, 1'b1};
    tbl[18] = '{1'b1, 2'd0, 16'd116,  1'b1, 1'b0, 4'h7, 13'h1fff, 1'b1};
    tbl[19] = '{1'b1, 2'd1, 16'd1,    1'b0, 1'b0, 4'h2, 13'h0400, 1'b1};
    tbl[20] = '{1'b1, 2'd0, 16'd19,   1'b0, 1'b1, 4'h7, 13'h1fff, 1'b1};
    tbl[21] = '{1'b1, 2'd0, 16'd1,    1'b1, 1'b0, 4'h7, 13'h1fff, 1'b1};

    aref_rst_n   = 1'b0;
    bus.init_end = 1'b0;
    bus.aref_en  = 1'b0;
    req_d1 = 1'b0;
    req_d2 = 1'b0;
    model_reset();
    #12;
    check_model();
    aref_rst_n = 1'b1;

    for (int r = 0; r < 22; r++) begin
      for (int c = 0; c < int'(tbl[r].n); c++) begin
        case (tbl[r].en_mode)
          2'd0:    en_v = 1'b0;
          2'd1:    en_v = 1'b1;
          default: en_v = req_d2;
        endcase
        step(tbl[r].init, en_v);
      end
      chk($sformatf("row%0d_req", r),  int'(bus.aref_req),  int'(tbl[r].exp_req));
      chk($sformatf("row%0d_end", r),  int'(bus.aref_end),  int'(tbl[r].exp_end));
      chk($sformatf("row%0d_cmd", r),  int'(bus.aref_cmd),  int'(tbl[r].exp_cmd));
      chk($sformatf("row%0d_addr", r), int'(bus.aref_addr), int'(tbl[r].exp_addr));
      chk($sformatf("row%0d_miss", r), int'(bus.aref_miss), int'(tbl[r].exp_miss));
    end

    // Reset asserted in the middle of a WTRFC wait, away from any clock edge
    step(1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
    chk("pre_rst_cmd", int'(bus.aref_cmd), 'h7);
    #2;
    aref_rst_n = 1'b0;
    #1;
    chk("rst_req",  int'(bus.aref_req),  0);
    chk("rst_end",  int'(bus.aref_end),  0);
    chk("rst_cmd",  int'(bus.aref_cmd),  'h7);
    chk("rst_bank", int'(bus.aref_bank), 'h3);
    chk("rst_addr", int'(bus.aref_addr), 'h1fff);
    chk("rst_miss", int'(bus.aref_miss), 0);
    model_reset();
    for (int c = 0; c < 15; c++) begin
      @(posedge aref_clk);
      #1;
      chk("rst_hold_end", int'(bus.aref_end), 0);
    end
    aref_rst_n = 1'b1;
    req_d1 = 1'b0;
    req_d2 = 1'b0;

    // init_end drops mid-sequence: the sequence still completes, backlog clears
    for (int c = 0; c < N; c++) step(1'b1, 1'b0);
    chk("reinit_req", int'(bus.aref_req), 1);
    step(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0);
    for (int c = 0; c < LEN; c++) step(1'b1, 1'b0);
    chk("init_drop_req", int'(bus.aref_req), 0);

    // Randomised traffic in blocks: random grant, grant held off, grant held on
    for (int b = 0; b < 40; b++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        init_v = ($urandom_range(0, 399) != 0);
        case (mode)
          0:       en_v = 1'($urandom_range(0, 1));
          1:       en_v = 1'b0;
          default: en_v = 1'b1;
        endcase
        step(init_v, en_v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
